relock_sweep: RTL and testbench

Parametrised successor to the single-channel relock sweeper. Relock_sweep sits between a servo loop filter output and the actuator summing node. When the error monitor signal leaves its lock window, it drives a triangle sweep of doubling amplitude. New behaviour over the previous generation:
- configurable widths
- debounced lock detection
- a programmable amplitude ceiling
- a sweep-count limit that raises a sticky fault
- saturating accumulator arithmetic

---
 rtl/relock_pkg.sv | 20 ++
 rtl/relock_lock_detect.sv | 66 ++++++
 rtl/relock_sweep.sv | 207 ++++++++++++++++++++
 tb/tb_relock_sweep.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relock_pkg.sv
// relock_pkg: shared constants for the relock sweeper.
// State encodings, amplitude seed shift, default widths.
package relock_pkg;

  localparam int DEF_IN_WIDTH    = 16;
  localparam int DEF_ACC_WIDTH   = 42;
  localparam int DEF_OUT_WIDTH   = 18;
  localparam int DEF_DWELL_WIDTH = 16;
  localparam int STEP_WIDTH      = 32;
  localparam int AMP_SEED_SHIFT  = 8;

  typedef enum logic [2:0] {
    ST_ZERO   = 3'd0,
    ST_UP     = 3'd1,
    ST_DOWN   = 3'd2,
    ST_RETURN = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

endpackage

// File: rtl/relock_lock_detect.sv
// relock_lock_detect: window compare with dwell debounce.
// in: on, window bounds, signal, dwell, rails; out: locked, clear pulse.
module relock_lock_detect
  import relock_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   on_in,
  input  logic [IN_WIDTH-1:0]    minval_in,
  input  logic [IN_WIDTH-1:0]    maxval_in,
  input  logic [IN_WIDTH-1:0]    signal_in,
  input  logic [DWELL_WIDTH-1:0] dwell_in,
  input  logic [1:0]             railed_in,
  output logic                   locked_out,
  output logic                   clear_out
);

  localparam logic [DWELL_WIDTH-1:0] CNT_ONE =
    {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  logic                   in_win;
  logic                   locked_q, locked_d;
  logic                   clear_q, clear_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

  assign in_win =
    ($signed(minval_in) < $signed(signal_in)) &&
    ($signed(signal_in) < $signed(maxval_in));

  // >= keeps the counter from running past a dwell
  // that was lowered while a disagreement was pending.
  always_comb begin
    locked_d = locked_q;
    cnt_d    = '0;
    clear_d  = 1'b0;
    if (!on_in) begin
      locked_d = 1'b1;
    end else if (in_win != locked_q) begin
      if (cnt_q >= dwell_in) begin
        locked_d = ~locked_q;
        clear_d  = locked_q && (railed_in != 2'b00);
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      locked_q <= 1'b1;
      clear_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      locked_q <= locked_d;
      clear_q  <= clear_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked_out = locked_q;
  assign clear_out  = clear_q;

endmodule

// File: rtl/relock_sweep.sv
// relock_sweep: triangle relock sweep with doubling amplitude.
// in: window/signal/step/ceiling/limits; out: hold, clear, lock, fault, state, sweep.
module relock_sweep
  import relock_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   on_in,
  input  logic [IN_WIDTH-1:0]    minval_in,
  input  logic [IN_WIDTH-1:0]    maxval_in,
  input  logic [IN_WIDTH-1:0]    signal_in,
  input  logic [STEP_WIDTH-1:0]  stepsize_in,
  input  logic [ACC_WIDTH-2:0]   amp_max_in,
  input  logic [7:0]             max_sweeps_in,
  input  logic [DWELL_WIDTH-1:0] dwell_in,
  input  logic [1:0]             railed_in,
  input  logic                   hold_in,
  output logic                   hold_out,
  output logic                   clear_out,
  output logic                   locked_out,
  output logic                   fault_out,
  output logic [2:0]             state_out,
  output logic [OUT_WIDTH-1:0]   signal_out
);

  localparam int AW = ACC_WIDTH - 1;
  // wide enough for step<<8 and for amp<<1
  localparam int WW = ACC_WIDTH + AMP_SEED_SHIFT;

  logic locked;

  relock_lock_detect #(
    .IN_WIDTH    (IN_WIDTH),
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_lock (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .on_in      (on_in),
    .minval_in  (minval_in),
    .maxval_in  (maxval_in),
    .signal_in  (signal_in),
    .dwell_in   (dwell_in),
    .railed_in  (railed_in),
    .locked_out (locked),
    .clear_out  (clear_out)
  );

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [AW-1:0]                 amp_q, amp_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic                          fault_q, fault_d;

  logic signed [ACC_WIDTH-1:0]   step, neg_step;
  logic signed [ACC_WIDTH-1:0]   amp_ext, neg_amp;
  logic signed [ACC_WIDTH-1:0]   acc_up, acc_dn, acc_rt;
  logic                          rt_done;
  logic [WW-1:0]                 seed_w, dbl_w, max_w;
  logic [WW-1:0]                 full_w, amp_w;
  logic [AW-1:0]                 amp_nx;
  logic [7:0]                    cnt_inc;
  logic                          fault_hit;

  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      sat_add = s[ACC_WIDTH]
        ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sat_add = s[ACC_WIDTH-1:0];
  endfunction

  assign step = $signed(
    {{(ACC_WIDTH-STEP_WIDTH){1'b0}}, stepsize_in});
  assign neg_step = -step;
  assign amp_ext  = $signed({1'b0, amp_q});
  assign neg_amp  = -amp_ext;

  assign acc_up = sat_add(acc_q, step);
  assign acc_dn = sat_add(acc_q, neg_step);

  // one step toward zero, snapping to zero inside +-step
  assign rt_done = !(acc_q > step) && !(acc_q < neg_step);
  assign acc_rt  = (acc_q > step)     ? acc_dn :
                   (acc_q < neg_step) ? acc_up : '0;

  assign seed_w = {{(WW-STEP_WIDTH-AMP_SEED_SHIFT){1'b0}},
                   stepsize_in, {AMP_SEED_SHIFT{1'b0}}};
  assign dbl_w  = {{(WW-ACC_WIDTH){1'b0}}, amp_q, 1'b0};
  assign max_w  = {{(WW-AW){1'b0}}, amp_max_in};
  assign full_w = {{(WW-AW){1'b0}}, {AW{1'b1}}};

  // the ceiling applies to doubling; the seed only
  // saturates to what the amplitude register can hold
  always_comb begin
    amp_w = (dbl_w < max_w) ? dbl_w : max_w;
    if (amp_q == '0)
      amp_w = seed_w;
    if (amp_w > full_w)
      amp_w = full_w;
  end

  assign amp_nx    = amp_w[AW-1:0];
  assign cnt_inc   = cnt_q + 8'd1;
  assign fault_hit = (max_sweeps_in != 8'd0) &&
                     (cnt_inc == max_sweeps_in);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amp_d   = amp_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (!on_in) begin
      state_d = ST_ZERO;
      acc_d   = '0;
      amp_d   = '0;
      cnt_d   = '0;
      fault_d = 1'b0;
    end else if (!hold_in) begin
      unique case (state_q)
        ST_ZERO: begin
          acc_d = '0;
          amp_d = '0;
          cnt_d = '0;
          if (!locked)
            state_d = ST_UP;
        end
        ST_UP: begin
          acc_d = acc_up;
          if (locked) begin
            state_d = ST_RETURN;
          end else if (acc_q > amp_ext || railed_in[1]) begin
            amp_d = amp_nx;
            cnt_d = cnt_inc;
            if (fault_hit) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              state_d = ST_DOWN;
            end
          end
        end
        ST_DOWN: begin
          acc_d = acc_dn;
          if (locked)
            state_d = ST_RETURN;
          else if (acc_q < neg_amp || railed_in[0])
            state_d = ST_UP;
        end
        ST_RETURN: begin
          amp_d = '0;
          cnt_d = '0;
          acc_d = acc_rt;
          if (!locked)
            state_d = ST_UP;
          else if (rt_done)
            state_d = ST_ZERO;
        end
        ST_FAULT: begin
          fault_d = 1'b1;
          acc_d   = acc_rt;
        end
        default: begin
          state_d = ST_ZERO;
          acc_d   = '0;
          amp_d   = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_ZERO;
      acc_q   <= '0;
      amp_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amp_q   <= amp_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign hold_out   = on_in & ~locked;
  assign locked_out = locked;
  assign fault_out  = fault_q;
  assign state_out  = state_q;
  assign signal_out = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: tb/tb_relock_sweep.sv
// tb_relock_sweep: directed bench for relock_sweep.
// Full-width signal_out so accumulator values compare exactly.
module tb_relock_sweep;

  localparam longint S = 64'sd1048576;

  logic        clk;
  logic        rst_n;
  logic        on;
  logic [15:0] minv, maxv, sig_in;
  logic [31:0] step;
  logic [40:0] amp_max;
  logic [7:0]  max_sw;
  logic [15:0] dwell;
  logic [1:0]  railed;
  logic        hold;
  logic        hold_o, clear_o, locked_o, fault_o;
  logic [2:0]  state_o;
  logic [41:0] sig_o;

  int n_checks;
  int n_errors;

  int     pk_st [11] = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
  longint pk_v  [11] = '{2, -258, 258, -514, 514, -1026,
                         1026, -2050, 2050, -2050, 2050};

  relock_sweep #(
    .IN_WIDTH    (16),
    .ACC_WIDTH   (42),
    .OUT_WIDTH   (42),
    .DWELL_WIDTH (16)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .on_in         (on),
    .minval_in     (minv),
    .maxval_in     (maxv),
    .signal_in     (sig_in),
    .stepsize_in   (step),
    .amp_max_in    (amp_max),
    .max_sweeps_in (max_sw),
    .dwell_in      (dwell),
    .railed_in     (railed),
    .hold_in       (hold),
    .hold_out      (hold_o),
    .clear_out     (clear_o),
    .locked_out    (locked_o),
    .fault_out     (fault_o),
    .state_out     (state_o),
    .signal_out    (sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sx(input logic [41:0] v);
    return {{22{v[41]}}, v};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d",
               tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st,
                            input int budget,
                            input string tag);
    int n;
    n = 0;
    while (state_o !== st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(state_o), 64'(st));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n   = 1'b0;
    on      = 1'b1;
    minv    = -16'sd100;
    maxv    = 16'sd100;
    sig_in  = 16'sd0;
    step    = 32'h0010_0000;
    amp_max = 41'd1 << 31;
    max_sw  = 8'd0;
    dwell   = 16'd0;
    railed  = 2'b00;
    hold    = 1'b0;

    tick();
    tick();
    chk("rst_locked", 64'(locked_o), 64'd1);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_sig", sx(sig_o), 64'd0);
    chk("rst_clear", 64'(clear_o), 64'd0);
    chk("rst_fault", 64'(fault_o), 64'd0);
    chk("rst_hold", 64'(hold_o), 64'd0);

    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_locked", 64'(locked_o), 64'd1);
    chk("idle_state", 64'(state_o), 64'd0);
    chk("idle_sig", sx(sig_o), 64'd0);

    // three disagreeing samples with dwell 3: no drop
    dwell  = 16'd3;
    sig_in = 16'sd200;
    repeat (3) tick();
    chk("dw3_locked", 64'(locked_o), 64'd1);
    sig_in = 16'sd0;
    tick();
    chk("dw3_back", 64'(locked_o), 64'd1);
    repeat (3) tick();
    chk("dw3_still", 64'(locked_o), 64'd1);

    // four disagreeing samples: drop on the fourth
    sig_in = 16'sd200;
    repeat (3) tick();
    chk("dw4_pre", 64'(locked_o), 64'd1);
    tick();
    chk("dw4_drop", 64'(locked_o), 64'd0);
    chk("dw4_state", 64'(state_o), 64'd0);
    chk("dw4_hold", 64'(hold_o), 64'd1);
    tick();
    chk("up_state", 64'(state_o), 64'd1);
    chk("up_sig", sx(sig_o), 64'd0);
    tick();
    chk("up_step1", sx(sig_o), 64'(S));

    // turn-around peaks; amplitude clamps at 2048 steps
    for (int i = 0; i < 11; i++) begin
      wait_state(3'(pk_st[i]), 5000, "pk_state");
      chk("pk_val", sx(sig_o), 64'(pk_v[i] * S));
    end

    on = 1'b0;
    tick();
    chk("off_state", 64'(state_o), 64'd0);
    chk("off_sig", sx(sig_o), 64'd0);
    chk("off_locked", 64'(locked_o), 64'd1);
    chk("off_hold", 64'(hold_o), 64'd0);

    // sweep limit 3: fault at third turn-around
    max_sw = 8'd3;
    on     = 1'b1;
    wait_state(3'd4, 5000, "flt_state");
    chk("flt_out", 64'(fault_o), 64'd1);
    chk("flt_peak", sx(sig_o), 64'(514 * S));
    repeat (513) tick();
    chk("flt_ramp", sx(sig_o), 64'(S));
    tick();
    chk("flt_zero", sx(sig_o), 64'd0);
    repeat (5) tick();
    chk("flt_stay", 64'(state_o), 64'd4);
    chk("flt_sticky", 64'(fault_o), 64'd1);
    chk("flt_hold0", sx(sig_o), 64'd0);
    sig_in = 16'sd0;
    on     = 1'b0;
    tick();
    chk("flt_clr", 64'(fault_o), 64'd0);
    chk("flt_clr_st", 64'(state_o), 64'd0);
    on     = 1'b1;
    max_sw = 8'd0;
    dwell  = 16'd0;
    tick();
    chk("relock_idle", 64'(locked_o), 64'd1);

    // unlock while railed high
    sig_in = 16'sd200;
    railed = 2'b10;
    tick();
    chk("rl_locked", 64'(locked_o), 64'd0);
    chk("rl_clear", 64'(clear_o), 64'd1);
    chk("rl_state0", 64'(state_o), 64'd0);
    tick();
    chk("rl_clear_end", 64'(clear_o), 64'd0);
    chk("rl_up", 64'(state_o), 64'd1);
    tick();
    chk("rl_turn", 64'(state_o), 64'd2);
    chk("rl_sig", sx(sig_o), 64'(S));
    railed = 2'b00;
    tick();
    chk("rl_down0", sx(sig_o), 64'd0);
    repeat (3) tick();
    chk("rl_down3", sx(sig_o), 64'(-3 * S));

    // relock mid-sweep: RETURN from -5 steps
    sig_in = 16'sd0;
    tick();
    chk("rt_locked", 64'(locked_o), 64'd1);
    chk("rt_sig4", sx(sig_o), 64'(-4 * S));
    tick();
    chk("rt_state", 64'(state_o), 64'd3);
    chk("rt_sig5", sx(sig_o), 64'(-5 * S));
    repeat (4) tick();
    chk("rt_sig1", sx(sig_o), 64'(-1 * S));
    chk("rt_state4", 64'(state_o), 64'd3);
    tick();
    chk("rt_zero", sx(sig_o), 64'd0);
    chk("rt_done", 64'(state_o), 64'd0);

    // hold freezes sweep; lock detector keeps running
    sig_in = 16'sd200;
    repeat (5) tick();
    chk("hd_pre_st", 64'(state_o), 64'd2);
    chk("hd_pre_sig", sx(sig_o), 64'(S));
    hold = 1'b1;
    repeat (5) tick();
    sig_in = 16'sd0;
    repeat (5) tick();
    chk("hd_sig", sx(sig_o), 64'(S));
    chk("hd_state", 64'(state_o), 64'd2);
    chk("hd_locked", 64'(locked_o), 64'd1);
    hold = 1'b0;
    tick();
    chk("hd_ret", 64'(state_o), 64'd3);
    chk("hd_ret_sig", sx(sig_o), 64'd0);
    tick();
    chk("hd_zero", 64'(state_o), 64'd0);

    // asynchronous reset mid-sweep
    sig_in = 16'sd200;
    repeat (5) tick();
    chk("ar_pre_sig", sx(sig_o), 64'(S));
    rst_n = 1'b0;
    #1;
    chk("ar_sig", sx(sig_o), 64'd0);
    chk("ar_state", 64'(state_o), 64'd0);
    chk("ar_locked", 64'(locked_o), 64'd1);
    chk("ar_hold", 64'(hold_o), 64'd0);
    chk("ar_clear", 64'(clear_o), 64'd0);
    chk("ar_fault", 64'(fault_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
